// File: rtl/mux_rr_arb_4_pkg.sv
// Shared definitions for the 4-way round-robin arbiter with data mux.
// Holds the FSM encoding, the hold limit default and the rotating-priority search.
package mux_rr_arb_4_pkg;

   typedef enum logic {
      StIdle = 1'b0,
      StBusy = 1'b1
   } arb_state_e;

   localparam int unsigned MaxHoldDefault = 4;

   // Returns {found, index} of the first set req bit searching ptr, ptr+1, ... (mod 4).
   function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      // Walk offsets high to low so the smallest offset from ptr is written last.
      for (int k = 3; k >= 0; k--) begin
         idx = ptr + 2'(k);
         if (req[idx]) begin
            res = {1'b1, idx};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/mux_rr_arb_4_mux.sv
// 4:1 multiplexer for 16-bit data, select driven by the arbiter's owner index.
module mux_4_1_16bit (
   input  logic [1:0]  sel_i,
   input  logic [15:0] in0_i,
   input  logic [15:0] in1_i,
   input  logic [15:0] in2_i,
   input  logic [15:0] in3_i,
   output logic [15:0] out_o
);

   always_comb begin
      out_o = 16'h0000;
      unique case (sel_i)
         2'd0:    out_o = in0_i;
         2'd1:    out_o = in1_i;
         2'd2:    out_o = in2_i;
         2'd3:    out_o = in3_i;
         default: out_o = 16'h0000;
      endcase
   end

endmodule

// File: rtl/mux_rr_arb_4.sv
// Round-robin arbiter for four requesters with bounded tenure and a gated data mux.
// Grant and select are registered; the data path from in0..in3 to out0 is combinational.
module mux_rr_arb_4
   import mux_rr_arb_4_pkg::*;
#(
   parameter int unsigned MAX_HOLD = MaxHoldDefault
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req,
   input  logic [15:0] in0,
   input  logic [15:0] in1,
   input  logic [15:0] in2,
   input  logic [15:0] in3,
   output logic [3:0]  gnt,
   output logic [1:0]  sel,
   output logic [15:0] out0,
   output logic        out_valid
);

   localparam logic [3:0] HoldMax = 4'(MAX_HOLD);

   arb_state_e  state_q, state_d;
   logic [3:0]  gnt_q, gnt_d;
   logic [1:0]  sel_q, sel_d;
   logic [1:0]  ptr_q, ptr_d;
   logic [3:0]  hold_q, hold_d;
   logic [2:0]  pick;
   logic        rel;
   logic [15:0] mux_out;

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      rel     = 1'b0;
      pick    = rr_pick(req, ptr_q);

      unique case (state_q)
         StIdle: begin
            gnt_d = 4'b0000;
            if (pick[2]) begin
               state_d = StBusy;
               sel_d   = pick[1:0];
               gnt_d   = 4'b0001 << pick[1:0];
               hold_d  = 4'd1;
            end
         end
         StBusy: begin
            rel = !req[sel_q] || (hold_q == HoldMax);
            if (rel) begin
               // The rotated pointer takes effect in the same cycle so handoff has no bubble.
               ptr_d = sel_q + 2'd1;
               pick  = rr_pick(req, ptr_d);
               if (pick[2]) begin
                  sel_d  = pick[1:0];
                  gnt_d  = 4'b0001 << pick[1:0];
                  hold_d = 4'd1;
               end else begin
                  state_d = StIdle;
                  gnt_d   = 4'b0000;
                  hold_d  = 4'd0;
               end
            end else if (hold_q < HoldMax) begin
               hold_d = hold_q + 4'd1;
            end
         end
         default: begin
            state_d = StIdle;
            gnt_d   = 4'b0000;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         gnt_q   <= 4'b0000;
         sel_q   <= 2'b00;
         ptr_q   <= 2'b00;
         hold_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
      end
   end

   mux_4_1_16bit u_mux (
      .sel_i (sel_q),
      .in0_i (in0),
      .in1_i (in1),
      .in2_i (in2),
      .in3_i (in3),
      .out_o (mux_out)
   );

   assign gnt       = gnt_q;
   assign sel       = sel_q;
   assign out_valid = |gnt_q;
   assign out0      = out_valid ? mux_out : 16'h0000;

endmodule
